// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic pipeline stage register.
// Defines the stage FSM encoding, the NOP control value and packed-word indexing.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_t;

  localparam logic [63:0] CTRL_NOP = '0;

  function automatic int unsigned word_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/pipeline_stage_elastic_slot.sv
// Load-enabled payload register (pipe_slot); cleared to zero by reset.
// The stage uses two of these: the main slot that drives outputs and the skid slot.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] payload_d;
  logic [W-1:0] payload_q;

  always_comb begin
    payload_d = load ? d : payload_q;
  end

  always_ff @(posedge clk) begin
    if (reset) payload_q <= '0;
    else       payload_q <= payload_d;
  end

  assign q = payload_q;

endmodule

// File: rtl/pipeline_stage_elastic.sv
// Valid/ready pipeline stage register with two-entry skid storage, flush and NOP bubbles.
// Optional PIPE_STAGE_STATS_EN adds saturating stall_cycles / flush_count counters.
module pipeline_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = 12,
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 6,
  parameter int ADDR_W   = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0]          in_rd_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]          out_rd_addr,
  output logic [1:0]                 occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]                stall_cycles,
  output logic [31:0]                flush_count
`endif
);

  localparam int BUS_W  = NUM_DATA * DATA_W;
  localparam int SLOT_W = CTRL_W + BUS_W + ADDR_W;

  stage_state_t      state_q, state_d;
  logic              accept, drain;
  logic              load_main, load_skid;
  logic [SLOT_W-1:0] in_payload, main_d, main_q, skid_q;

  assign accept     = in_valid & in_ready;
  assign drain      = out_valid & out_ready;
  assign in_payload = {in_ctrl, in_data, in_rd_addr};

  pipe_slot #(.W(SLOT_W)) u_main (
    .clk(clk), .reset(reset), .load(load_main), .d(main_d), .q(main_q)
  );

  pipe_slot #(.W(SLOT_W)) u_skid (
    .clk(clk), .reset(reset), .load(load_skid), .d(in_payload), .q(skid_q)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Main slot refills from the skid when draining FULL, otherwise from the input.
  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    main_d    = in_payload;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d   = ONE;
          load_main = 1'b1;
          main_d    = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  // Ready depends only on registered state, so no ready chain forms across stages.
  always_comb begin
    in_ready  = !reset && (state_q != FULL);
    out_valid = (state_q != EMPTY);
    case (state_q)
      ONE:     occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign out_ctrl    = out_valid ? main_q[SLOT_W-1 -: CTRL_W] : CTRL_NOP[CTRL_W-1:0];
  assign out_data    = out_valid ? main_q[ADDR_W +: BUS_W]    : '0;
  assign out_rd_addr = out_valid ? main_q[ADDR_W-1:0]         : '0;

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cycles_d, stall_cycles_q;
  logic [31:0] flush_count_d, flush_count_q;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (out_valid && !out_ready && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (flush && (state_q != EMPTY) && (flush_count_q != 32'hFFFF_FFFF))
      flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule
